// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency RAM between instruction fetch and load/store traffic.
// MEM wins over IF; a taken branch kills the fetch that is in flight or about to complete.
module mem_port_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  input  logic        i_branch_taken,
  input  logic        i_mem_rd_req,
  input  logic        i_mem_wr_req,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  output logic [31:0] o_if_instr,
  output logic        o_if_valid,
  output logic [31:0] o_mem_rdata,
  output logic        o_mem_done,
  output logic        o_freeze,
  output logic        o_ram_en,
  output logic        o_ram_we,
  output logic [31:0] o_ram_addr,
  output logic [31:0] o_ram_wdata,
  input  logic [31:0] i_ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_INIT = CNT_W'(ACCESS_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_kill;
  logic              r_we;
  logic              r_is_fetch;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_instr;
  logic [31:0]       r_rdata;
  logic              w_mem_req;

  assign w_mem_req = i_mem_rd_req | i_mem_wr_req;

  always_comb begin
    w_state_next = r_state;
    o_ram_en     = 1'b0;
    o_ram_we     = 1'b0;
    o_if_valid   = 1'b0;
    o_mem_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_req)
          w_state_next = S_DATA;
        else if (i_if_req && !i_branch_taken)
          w_state_next = S_FETCH;
      end
      S_FETCH: begin
        o_ram_en = 1'b1;
        if (r_cnt == '0)
          w_state_next = S_DONE;
      end
      S_DATA: begin
        o_ram_en = 1'b1;
        o_ram_we = r_we;
        if (r_cnt == '0)
          w_state_next = S_DONE;
      end
      S_DONE: begin
        // A branch arriving in the completion cycle still squashes the fetch.
        o_if_valid   = r_is_fetch & ~r_kill & ~i_branch_taken;
        o_mem_done   = ~r_is_fetch;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    o_freeze = (i_if_req & ~o_if_valid) | (w_mem_req & ~o_mem_done);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_kill     <= 1'b0;
      r_we       <= 1'b0;
      r_is_fetch <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_instr    <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_state_next != S_IDLE) begin
            r_addr     <= w_mem_req ? i_mem_addr : i_if_addr;
            r_wdata    <= i_mem_wdata;
            r_we       <= i_mem_wr_req;
            r_is_fetch <= ~w_mem_req;
            r_cnt      <= LP_CNT_INIT;
            r_kill     <= 1'b0;
          end
        end
        S_FETCH, S_DATA: begin
          // The RAM access always runs to completion; a kill only hides the result.
          if (r_state == S_FETCH && i_branch_taken)
            r_kill <= 1'b1;
          if (r_cnt == '0) begin
            if (r_is_fetch)
              r_instr <= i_ram_rdata;
            else if (!r_we)
              r_rdata <= i_ram_rdata;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DONE: r_kill <= 1'b0;
        default: r_kill <= 1'b0;
      endcase
    end
  end

  assign o_ram_addr  = r_addr;
  assign o_ram_wdata = r_wdata;
  assign o_if_instr  = r_instr;
  assign o_mem_rdata = r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (2-cycle and 1-cycle RAM) checked every cycle
// against a timeline model, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic [1:0]  rst = 2'b11;
  logic [1:0]  if_req = '0, bt = '0, rd = '0, wr = '0;
  logic [31:0] if_addr [2];
  logic [31:0] maddr [2];
  logic [31:0] wdata [2];
  logic [31:0] ram_rdata [2];
  logic [31:0] if_instr [2];
  logic [31:0] mem_rdata [2];
  logic [31:0] ram_addr [2];
  logic [31:0] ram_wdata [2];
  logic [1:0]  if_valid, mem_done, freeze, ram_en, ram_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      mem_port_arbiter #(.ACCESS_CYCLES(gi == 0 ? 2 : 1), .CNT_W(4)) u_dut (
        .i_clk(clk), .i_rst(rst[gi]),
        .i_if_req(if_req[gi]), .i_if_addr(if_addr[gi]), .i_branch_taken(bt[gi]),
        .i_mem_rd_req(rd[gi]), .i_mem_wr_req(wr[gi]),
        .i_mem_addr(maddr[gi]), .i_mem_wdata(wdata[gi]),
        .o_if_instr(if_instr[gi]), .o_if_valid(if_valid[gi]),
        .o_mem_rdata(mem_rdata[gi]), .o_mem_done(mem_done[gi]), .o_freeze(freeze[gi]),
        .o_ram_en(ram_en[gi]), .o_ram_we(ram_we[gi]),
        .o_ram_addr(ram_addr[gi]), .o_ram_wdata(ram_wdata[gi]),
        .i_ram_rdata(ram_rdata[gi])
      );
    end
  endgenerate

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  function automatic int acc(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  // Model: an accepted transaction is a point on a timeline; phase p counts cycles after
  // the accept edge. RAM busy for p=1..ACC, completion pulse at p=ACC+1, idle afterwards.
  typedef struct {
    bit          busy;
    int          ph;
    int          kind;   // 0 fetch, 1 load, 2 store
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] instr;
    logic [31:0] rdata;
    bit          killed;
  } mst_t;

  mst_t ms [2];
  bit          e_en, e_we, e_iv, e_md, e_fz;
  logic [31:0] e_in, e_rd;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int a;
      a = acc(d);
      e_en = 0; e_we = 0; e_iv = 0; e_md = 0;
      if (rst[d]) begin
        ms[d] = '{default: 0};
      end else if (ms[d].busy) begin
        e_en = (ms[d].ph <= a);
        e_we = e_en && (ms[d].kind == 2);
        e_iv = (ms[d].ph == a + 1) && (ms[d].kind == 0) && !ms[d].killed && !bt[d];
        e_md = (ms[d].ph == a + 1) && (ms[d].kind != 0);
      end
      e_in = ms[d].instr;
      e_rd = ms[d].rdata;
      e_fz = (if_req[d] && !e_iv) || ((rd[d] || wr[d]) && !e_md);

      chk("ram_en", d, ram_en[d], e_en);
      chk("ram_we", d, ram_we[d], e_we);
      chk("if_valid", d, if_valid[d], e_iv);
      chk("mem_done", d, mem_done[d], e_md);
      chk("freeze", d, freeze[d], e_fz);
      chk("if_instr", d, if_instr[d], e_in);
      chk("mem_rdata", d, mem_rdata[d], e_rd);
      if (rst[d]) begin
        chk("ram_addr_rst", d, ram_addr[d], 32'h0);
        chk("ram_wdata_rst", d, ram_wdata[d], 32'h0);
      end
      if (e_en) chk("ram_addr", d, ram_addr[d], ms[d].addr);
      if (e_we) chk("ram_wdata", d, ram_wdata[d], ms[d].wdata);

      if (!rst[d]) begin
        if (ms[d].busy) begin
          if (ms[d].kind == 0 && ms[d].ph <= a && bt[d]) ms[d].killed = 1;
          if (ms[d].ph == a) begin
            if (ms[d].kind == 0) ms[d].instr = ram_rdata[d];
            else if (ms[d].kind == 1) ms[d].rdata = ram_rdata[d];
          end
          ms[d].ph++;
          if (ms[d].ph > a + 1) ms[d].busy = 0;
        end else if (rd[d] || wr[d]) begin
          ms[d].busy = 1; ms[d].ph = 1; ms[d].killed = 0;
          ms[d].kind = rd[d] ? 1 : 2;
          ms[d].addr = maddr[d]; ms[d].wdata = wdata[d];
        end else if (if_req[d] && !bt[d]) begin
          ms[d].busy = 1; ms[d].ph = 1; ms[d].killed = 0;
          ms[d].kind = 0;
          ms[d].addr = if_addr[d]; ms[d].wdata = wdata[d];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  logic [8:0] v_pat, e_pat;

  initial begin
    for (int d = 0; d < 2; d++) begin
      if_addr[d] = '0; maddr[d] = '0; wdata[d] = '0; ram_rdata[d] = '0;
    end
    repeat (3) tick();
    peek();
    chk("rst_ram_en", 0, ram_en[0], 1'b0);
    chk("rst_if_instr", 0, if_instr[0], 32'h0);
    chk("rst_freeze", 0, freeze[0], 1'b0);
    tick();
    rst = 2'b00;
    tick();

    // 1) single fetch
    if_req[0] = 1; if_addr[0] = 32'h10; ram_rdata[0] = 32'hDEADBEEF;
    tick(); peek();
    chk("t1_ram_en_c1", 0, ram_en[0], 1'b1);
    chk("t1_freeze_c1", 0, freeze[0], 1'b1);
    chk("t1_addr", 0, ram_addr[0], 32'h10);
    tick(); peek();
    chk("t1_ram_en_c2", 0, ram_en[0], 1'b1);
    tick(); peek();
    chk("t1_if_valid", 0, if_valid[0], 1'b1);
    chk("t1_if_instr", 0, if_instr[0], 32'hDEADBEEF);
    chk("t1_freeze_c3", 0, freeze[0], 1'b0);
    if_req[0] = 0;
    tick();

    // 2) simultaneous load and fetch: load first
    if_req[0] = 1; if_addr[0] = 32'h20; rd[0] = 1; maddr[0] = 32'h40; ram_rdata[0] = 32'hA5A50001;
    tick(); peek();
    chk("t2_addr_load", 0, ram_addr[0], 32'h40);
    tick(); tick(); peek();
    chk("t2_mem_done", 0, mem_done[0], 1'b1);
    chk("t2_mem_rdata", 0, mem_rdata[0], 32'hA5A50001);
    chk("t2_no_if_valid", 0, if_valid[0], 1'b0);
    rd[0] = 0; ram_rdata[0] = 32'h0BADF00D;
    tick(); peek();
    chk("t2_idle_c4", 0, ram_en[0], 1'b0);
    tick(); peek();
    chk("t2_fetch_addr", 0, ram_addr[0], 32'h20);
    tick(); tick(); peek();
    chk("t2_if_valid_c7", 0, if_valid[0], 1'b1);
    chk("t2_if_instr", 0, if_instr[0], 32'h0BADF00D);
    if_req[0] = 0;
    tick();

    // 3) branch during fetch, then branch in the completion cycle
    if_req[0] = 1; if_addr[0] = 32'h30; ram_rdata[0] = 32'h33330000;
    tick(); bt[0] = 1; peek();
    chk("t3_fetch_runs", 0, ram_en[0], 1'b1);
    tick(); bt[0] = 0;
    tick(); peek();
    chk("t3_killed", 0, if_valid[0], 1'b0);
    tick(); peek();
    chk("t3_idle_c4", 0, ram_en[0], 1'b0);
    tick(); peek();
    chk("t3_refetch", 0, ram_en[0], 1'b1);
    ram_rdata[0] = 32'h44440000;
    tick(); tick(); bt[0] = 1; peek();
    chk("t3_done_branch", 0, if_valid[0], 1'b0);
    if_req[0] = 0; bt[0] = 0;
    tick();

    // 4) store
    wr[0] = 1; maddr[0] = 32'h80; wdata[0] = 32'h12345678; ram_rdata[0] = 32'hFFFFFFFF;
    tick(); peek();
    chk("t4_we_c1", 0, ram_we[0], 1'b1);
    chk("t4_wdata", 0, ram_wdata[0], 32'h12345678);
    chk("t4_addr", 0, ram_addr[0], 32'h80);
    tick(); peek();
    chk("t4_we_c2", 0, ram_we[0], 1'b1);
    tick(); peek();
    chk("t4_mem_done", 0, mem_done[0], 1'b1);
    chk("t4_rdata_kept", 0, mem_rdata[0], 32'hA5A50001);
    wr[0] = 0;
    tick();

    // 5) reset in the middle of a load
    rd[0] = 1; maddr[0] = 32'h44; ram_rdata[0] = 32'h55550000;
    tick();
    #2; rst[0] = 1; rd[0] = 0;
    #1;
    chk("t5_ram_en_async", 0, ram_en[0], 1'b0);
    chk("t5_if_instr", 0, if_instr[0], 32'h0);
    chk("t5_mem_rdata", 0, mem_rdata[0], 32'h0);
    tick(); rst[0] = 0;
    rd[0] = 1; maddr[0] = 32'h48; ram_rdata[0] = 32'h77770000;
    tick(); peek();
    chk("t5_after_rst_en", 0, ram_en[0], 1'b1);
    tick(); tick(); peek();
    chk("t5_after_rst_done", 0, mem_done[0], 1'b1);
    chk("t5_after_rst_data", 0, mem_rdata[0], 32'h77770000);
    rd[0] = 0;
    tick();

    // 6) single-cycle RAM, continuous fetch
    if_req[1] = 1; if_addr[1] = 32'h100; ram_rdata[1] = 32'hC0DE0001;
    v_pat = '0; e_pat = '0;
    for (int i = 0; i < 9; i++) begin
      tick(); peek();
      v_pat[i] = if_valid[1];
      e_pat[i] = ram_en[1];
    end
    chk("t6_if_valid_pattern", 1, {23'h0, v_pat}, 32'h092);
    chk("t6_ram_en_pattern", 1, {23'h0, e_pat}, 32'h049);
    chk("t6_if_instr", 1, if_instr[1], 32'hC0DE0001);
    tick();
    if_req[1] = 0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
